reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor of the integer register file (x0..x(DEPTH-1)); x0 is hard-wired to zero.
- Adds a configurable number of read ports, optional same-cycle write-to-read bypass, optional synchronous clear, RV32E depth support, and a per-register busy scoreboard.
- The decode stage uses the scoreboard to detect RAW/WAW hazards against in-flight writebacks.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
- XLEN, 32, data width in bits.
- ADDR_W, 5, register address width.
- DEPTH, 32, number of architectural registers (16 for RV32E); must be ≤ 2^ADDR_W.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads.
- RESET_CLEAR, 1, 1 = all registers clear to 0 on reset; 0 = register contents are untouched by reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- reg_wen  in  1  writeback write enable.
- reg_waddr  in  ADDR_W  writeback address.
- reg_wdata  in  XLEN  writeback data.
- rd_raddr  in  NRD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- rd_rdata  out  NRD*XLEN  read data, packed the same way as rd_raddr.
- rd_busy  out  NRD  port i source register has a pending write that is not forwarded this cycle.
- issue_en  in  1  decode requests to mark issue_rd busy.
- issue_rd  in  ADDR_W  destination register of the issuing instruction.
- issue_ready  out  1  issue_rd is not busy (no WAW hazard); an issue is accepted only when issue_en & issue_ready.
- busy_vec  out  DEPTH  scoreboard state, for debug and coverage; bit 0 is always 0.

Behaviour:
Validity
- An address is valid iff addr != 0 and addr < DEPTH.
- Invalid addresses: reads return 0 and rd_busy = 0; writes are dropped; issue is ignored and issue_ready = 1.

Write path
- At posedge clk, if rst_n & reg_wen & valid(reg_waddr): reg[reg_waddr] <= reg_wdata.
- Reads are asynchronous, so a non-bypassed read sees the new value in the cycle after the write edge.

Read path (combinational)
- rd_rdata_i = 0 if raddr_i is invalid.
- Otherwise, if BYPASS & reg_wen & (reg_waddr == raddr_i): rd_rdata_i = reg_wdata.
- Otherwise rd_rdata_i = reg[raddr_i].
- Ports are fully independent; any ports may share an address.

Scoreboard
- One busy bit per register; bit 0 is constant 0.
- Set at the next edge when issue_en & issue_ready & valid(issue_rd).
- Cleared at the next edge when reg_wen & valid(reg_waddr).
- Simultaneous set and clear on the same address: set wins (a new producer is outstanding).
- rd_busy_i = busy[raddr_i] & ~(BYPASS & reg_wen & reg_waddr == raddr_i).
- issue_ready = ~busy[issue_rd] | (reg_wen & reg_waddr == issue_rd). Same-cycle retirement frees the slot; the set then wins.
- issue_en while issue_ready = 0: no state change. Decode must hold the request until issue_ready = 1.

Reset (rst_n sampled low at posedge)
- All busy bits are cleared.
- If RESET_CLEAR = 1, all registers are cleared to 0.
- Writes and issues in the reset cycle are ignored.
- Combinational outputs follow the post-reset state in the next cycle: rd_rdata = 0 (RESET_CLEAR = 1), rd_busy = 0, issue_ready = 1, busy_vec = 0.
- A reset asserted mid-operation discards all pending busy state; no in-flight write completes.

Latency
- Read: 0 cycles.
- Write visibility: 0 cycles with bypass, 1 cycle without.
- Scoreboard update: 1 cycle.

Decomposition:
- Shared header rvseed_defines.v holds CPU_WIDTH, REG_ADDR_WIDTH and REG_DATA_DEPTH; these are the parameter defaults. Add REG_DEPTH_E = 16.
- Sub-module reg_scoreboard (DEPTH, ADDR_W) owns the busy bits and the issue_ready / set / clear logic.
- Top-level reg_file_sb owns the storage array, the NRD read muxes generated with a generate loop, and the bypass logic.

Test Plan:
- Reset then reads: rst_n = 0 for one edge with RESET_CLEAR = 1 -> all rd_rdata = 0, busy_vec = 0, issue_ready = 1.
- x0 protection: write x0 = 0xDEADBEEF, then read x0 on every port -> 0, busy_vec[0] = 0.
- Bypass: with BYPASS = 1, write x5 = 0x1234 while port 1 reads x5 -> 0x1234 in the same cycle. With BYPASS = 0 -> old value this cycle, 0x1234 the next cycle.
- Scoreboard RAW: issue rd = x7 -> busy_vec[7] = 1 next cycle; read x7 -> rd_busy = 1; write x7 = 0x55 -> rd_busy = 0 in that cycle (BYPASS = 1), busy clear next cycle.
- WAW and collision: x9 busy, issue x9 with no write -> issue_ready = 0 and busy_vec unchanged. Issue x9 together with a writeback of x9 -> accepted, busy_vec[9] stays 1.
- RV32E: DEPTH = 16, write x20 = 0xFF, read x20 -> 0; issue x20 -> ignored, busy_vec unchanged. Reset during busy x3 -> busy_vec = 0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared widths for the integer register file and scoreboard, plus address validity.
// Defaults describe the RV32I file; REG_DEPTH_E is the RV32E register count.
package reg_file_sb_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_DEPTH = 32;
  localparam int REG_DEPTH_E    = 16;

  // x0 and anything beyond the implemented depth behave as "no register".
  function automatic logic addr_valid(input logic [31:0] addr, input int unsigned depth);
    return (addr != 32'd0) && (addr < depth);
  endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy bits tracking in-flight writebacks; issue_ready is combinational.
// Busy state updates one cycle after issue/writeback. A refused issue leaves state untouched.
// Decode must hold the request until issue_ready is high.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int DEPTH  = REG_DATA_DEPTH,
  parameter int ADDR_W = REG_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [DEPTH-1:0]  busy_vec
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] busy_q;
  logic             issue_valid;
  logic             wr_valid;
  logic             issue_busy;
  logic             wr_hit;

  assign issue_valid = addr_valid(32'(issue_rd), DEPTH);
  assign wr_valid    = addr_valid(32'(wr_addr), DEPTH);
  assign issue_busy  = issue_valid & busy_q[issue_rd[IDX_W-1:0]];
  assign wr_hit      = wr_en & wr_valid & (wr_addr == issue_rd);
  assign issue_ready = ~issue_busy | wr_hit;

  // Set is applied after clear so a new producer on a retiring register stays outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      if (wr_en && wr_valid)
        busy_q[wr_addr[IDX_W-1:0]] <= 1'b0;
      if (issue_en && issue_ready && issue_valid)
        busy_q[issue_rd[IDX_W-1:0]] <= 1'b1;
    end
  end

  assign busy_vec = {busy_q[DEPTH-1:1], 1'b0};

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with NRD async read ports, optional write bypass and a busy scoreboard.
// Reads take 0 cycles. Writes are visible in 0 cycles with bypass, 1 cycle without.
// No backpressure on reads or writes; issue is gated by issue_ready.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN        = CPU_WIDTH,
  parameter int ADDR_W      = REG_ADDR_WIDTH,
  parameter int DEPTH       = REG_DATA_DEPTH,
  parameter int NRD         = 2,
  parameter bit BYPASS      = 1'b1,
  parameter bit RESET_CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_wen,
  input  logic [ADDR_W-1:0]     reg_waddr,
  input  logic [XLEN-1:0]       reg_wdata,
  input  logic [NRD*ADDR_W-1:0] rd_raddr,
  output logic [NRD*XLEN-1:0]   rd_rdata,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_rd,
  output logic                  issue_ready,
  output logic [DEPTH-1:0]      busy_vec
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] regs [DEPTH];
  logic            w_valid;

  assign w_valid = addr_valid(32'(reg_waddr), DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (RESET_CLEAR) begin
        for (int i = 0; i < DEPTH; i++)
          regs[i] <= '0;
      end
    end else if (reg_wen && w_valid) begin
      regs[reg_waddr[IDX_W-1:0]] <= reg_wdata;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              r_valid;
    logic              fwd;

    assign ra      = rd_raddr[p*ADDR_W +: ADDR_W];
    assign r_valid = addr_valid(32'(ra), DEPTH);
    assign fwd     = BYPASS && reg_wen && (reg_waddr == ra);

    assign rd_rdata[p*XLEN +: XLEN] = !r_valid ? '0 :
                                      fwd      ? reg_wdata :
                                                 regs[ra[IDX_W-1:0]];
    // A forwarded write resolves the hazard within this cycle.
    assign rd_busy[p] = r_valid & busy_vec[ra[IDX_W-1:0]] & ~fwd;
  end

  reg_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .wr_en       (reg_wen),
    .wr_addr     (reg_waddr),
    .busy_vec    (busy_vec)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Three register files share one stimulus stream: bypass/32, no-bypass/32 and bypass/RV32E.
// Expected responses are queued per cycle and checked by a negedge monitor.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [9:0]  rd_raddr;
  logic        issue_en;
  logic [4:0]  issue_rd;

  logic [63:0] rdata_a, rdata_b, rdata_e;
  logic [1:0]  busy_a, busy_b, busy_e;
  logic        ready_a, ready_b, ready_e;
  logic [31:0] bvec_a, bvec_b;
  logic [15:0] bvec_e;

  always #5 clk = ~clk;

  reg_file_sb #(.DEPTH(32), .NRD(2), .BYPASS(1'b1), .RESET_CLEAR(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .rd_raddr(rd_raddr), .rd_rdata(rdata_a), .rd_busy(busy_a),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_ready(ready_a), .busy_vec(bvec_a));

  reg_file_sb #(.DEPTH(32), .NRD(2), .BYPASS(1'b0), .RESET_CLEAR(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .rd_raddr(rd_raddr), .rd_rdata(rdata_b), .rd_busy(busy_b),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_ready(ready_b), .busy_vec(bvec_b));

  reg_file_sb #(.DEPTH(16), .NRD(2), .BYPASS(1'b1), .RESET_CLEAR(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n), .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .rd_raddr(rd_raddr), .rd_rdata(rdata_e), .rd_busy(busy_e),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_ready(ready_e), .busy_vec(bvec_e));

  localparam int K_RD0 = 0, K_RD1 = 1, K_BSY0 = 2, K_BSY1 = 3, K_RDY = 4, K_BVEC = 5;

  typedef struct {
    int          dut;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] actual(input int dut, input int kind);
    logic [63:0] rd;
    logic [1:0]  bs;
    logic        rdy;
    logic [31:0] bv;
    case (dut)
      0:       begin rd = rdata_a; bs = busy_a; rdy = ready_a; bv = bvec_a; end
      1:       begin rd = rdata_b; bs = busy_b; rdy = ready_b; bv = bvec_b; end
      default: begin rd = rdata_e; bs = busy_e; rdy = ready_e; bv = {16'h0, bvec_e}; end
    endcase
    case (kind)
      K_RD0:   return rd[31:0];
      K_RD1:   return rd[63:32];
      K_BSY0:  return {31'h0, bs[0]};
      K_BSY1:  return {31'h0, bs[1]};
      K_RDY:   return {31'h0, rdy};
      default: return bv;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] a;
    while (q.size() > 0) begin
      c = q.pop_front();
      a = actual(c.dut, c.kind);
      total++;
      if (a !== c.exp) begin
        bad++;
        $display("FAIL %s dut%0d: got %h want %h", c.name, c.dut, a, c.exp);
      end
    end
  end

  task automatic expect1(input int dut, input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.dut = dut; c.kind = kind; c.exp = exp; c.name = name;
    q.push_back(c);
  endtask

  task automatic expect3(input int kind, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ee, input string name);
    expect1(0, kind, ea, name);
    expect1(1, kind, eb, name);
    expect1(2, kind, ee, name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    reg_wen  = 1'b0;
    issue_en = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    reg_wen   = 1'b1;
    reg_waddr = 5'(addr);
    reg_wdata = data;
  endtask

  task automatic issue(input int rd);
    issue_en = 1'b1;
    issue_rd = 5'(rd);
  endtask

  task automatic setr(input int a0, input int a1);
    rd_raddr = {5'(a1), 5'(a0)};
  endtask

  initial begin
    rst_n = 1'b0; reg_wen = 1'b0; reg_waddr = '0; reg_wdata = '0;
    rd_raddr = '0; issue_en = 1'b0; issue_rd = '0;
    #1;
    step();                                   // initial reset
    rst_n = 1'b1; wr(5, 32'hAAAA); step();
    rst_n = 1'b0; wr(6, 32'h77); issue(3); step();   // reset clears x5; write/issue ignored

    rst_n = 1'b1; setr(5, 6); issue_rd = 5'd3;
    expect3(K_RD0, 0, 0, 0, "rst_x5");
    expect3(K_RD1, 0, 0, 0, "rst_x6");
    expect3(K_BVEC, 0, 0, 0, "rst_busyvec");
    expect3(K_RDY, 1, 1, 1, "rst_ready");
    step();

    wr(0, 32'hDEADBEEF); setr(0, 0); issue_rd = 5'd0;
    expect3(K_RD0, 0, 0, 0, "x0_bypass_p0");
    expect3(K_RD1, 0, 0, 0, "x0_bypass_p1");
    expect3(K_RDY, 1, 1, 1, "x0_issue_ready");
    step();
    expect3(K_RD0, 0, 0, 0, "x0_after_p0");
    expect3(K_RD1, 0, 0, 0, "x0_after_p1");
    expect3(K_BVEC, 0, 0, 0, "x0_busyvec");
    step();

    wr(5, 32'h1234); setr(1, 5);
    expect3(K_RD1, 32'h1234, 32'h0, 32'h1234, "bypass_same_cycle");
    expect3(K_RD0, 0, 0, 0, "bypass_other_port");
    step();
    expect3(K_RD1, 32'h1234, 32'h1234, 32'h1234, "write_next_cycle");
    step();

    issue(7);
    expect3(K_RDY, 1, 1, 1, "raw_issue_ready");
    step();
    setr(7, 0); issue_rd = 5'd9;
    expect3(K_BVEC, 32'h80, 32'h80, 32'h80, "raw_busyvec_set");
    expect3(K_BSY0, 1, 1, 1, "raw_rd_busy");
    step();
    wr(7, 32'h55); setr(7, 0);
    expect3(K_BSY0, 0, 1, 0, "raw_busy_fwd");
    expect3(K_RD0, 32'h55, 32'h0, 32'h55, "raw_data_fwd");
    expect3(K_BVEC, 32'h80, 32'h80, 32'h80, "raw_busy_still_set");
    step();
    issue(9);
    expect3(K_BVEC, 0, 0, 0, "raw_busy_cleared");
    expect3(K_BSY0, 0, 0, 0, "raw_rd_busy_cleared");
    expect3(K_RD0, 32'h55, 32'h55, 32'h55, "raw_data_after");
    expect3(K_RDY, 1, 1, 1, "waw_first_issue");
    step();

    issue(9);
    expect3(K_RDY, 0, 0, 0, "waw_blocked");
    expect3(K_BVEC, 32'h200, 32'h200, 32'h200, "waw_busyvec");
    step();
    issue(9); wr(9, 32'h99);
    expect3(K_BVEC, 32'h200, 32'h200, 32'h200, "waw_unchanged");
    expect3(K_RDY, 1, 1, 1, "collide_ready");
    step();
    setr(9, 0);
    expect3(K_BVEC, 32'h200, 32'h200, 32'h200, "collide_set_wins");
    expect3(K_RD0, 32'h99, 32'h99, 32'h99, "collide_data");
    expect3(K_BSY0, 1, 1, 1, "collide_rd_busy");
    step();

    wr(20, 32'hFF); issue(20); setr(9, 20);
    expect3(K_RDY, 1, 1, 1, "x20_ready");
    expect3(K_RD1, 32'hFF, 32'h0, 32'h0, "x20_bypass");
    expect3(K_BSY1, 0, 0, 0, "x20_rd_busy");
    step();
    expect3(K_RD1, 32'hFF, 32'hFF, 32'h0, "x20_readback");
    expect3(K_BVEC, 32'h00100200, 32'h00100200, 32'h200, "x20_busyvec");
    issue(3);
    step();

    expect3(K_BVEC, 32'h00100208, 32'h00100208, 32'h208, "pre_reset_busy");
    rst_n = 1'b0; wr(9, 32'h1111);
    step();
    rst_n = 1'b1; setr(9, 20); issue_rd = 5'd3;
    expect3(K_BVEC, 0, 0, 0, "midrst_busyvec");
    expect3(K_RD0, 0, 0, 0, "midrst_x9");
    expect3(K_RD1, 0, 0, 0, "midrst_x20");
    expect3(K_RDY, 1, 1, 1, "midrst_ready");
    expect3(K_BSY0, 0, 0, 0, "midrst_rd_busy");
    step();

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
